// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lab3 stopwatch: FSM encoding, BCD time
// payload and the two-digit BCD increment used by both counting and adjust.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned SEC_WRAP_TENS = 5;
  localparam int unsigned DIGIT_MAX     = 9;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  typedef struct packed {
    bcd2_t mm;
    bcd2_t ss;
  } mmss_t;

  // Two-digit BCD +1 that wraps to 00 once the given maximum is reached.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t max_v);
    bcd2_t r;
    if (v == max_v) begin
      r = '0;
    end else if (v.ones >= DIGIT_W'(DIGIT_MAX)) begin
      r.tens = v.tens + DIGIT_W'(1);
      r.ones = '0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, sampled-level debounce and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_SAMPLES + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive samples disagreeing with the current debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_in};
      press <= 1'b0;
      if (sample_en) begin
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEB_SAMPLES - 1)) begin
          cnt   <= '0;
          level <= sync[1];
          press <= sync[1];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: RUN/PAUSE/ADJ state machine, MM:SS BCD counter
// and per-field blink blanking for the seven-segment driver.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_SAMPLES = 3,
  parameter int unsigned MAX_MIN     = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk1_en,
  input  logic               clk2_en,
  input  logic               clk3_en,
  input  logic               clk4_en,
  input  logic               btn_pause,
  input  logic               btn_reset,
  input  logic               sw_adj,
  input  logic               sw_sel,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               blank_min,
  output logic               blank_sec,
  output logic               running
);

  localparam bcd2_t SEC_MAX = bcd2_t'({DIGIT_W'(SEC_WRAP_TENS), DIGIT_W'(DIGIT_MAX)});
  localparam bcd2_t MIN_MAX = bcd2_t'({DIGIT_W'(MAX_MIN / 10), DIGIT_W'(MAX_MIN % 10)});

  logic [1:0] adj_sync;
  logic [1:0] sel_sync;
  logic       adj;
  logic       sel;
  logic       pause_press;
  logic       clr_press;
  logic [1:0] unused_levels;

  state_t state_q, state_d;
  mmss_t  time_q, time_d;
  logic   blink_q, blink_d;

  assign adj = adj_sync[1];
  assign sel = sel_sync[1];

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_pause_deb (
    .clk       (clk),
    .rst       (rst),
    .sample_en (clk3_en),
    .btn_in    (btn_pause),
    .level     (unused_levels[0]),
    .press     (pause_press)
  );

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_reset_deb (
    .clk       (clk),
    .rst       (rst),
    .sample_en (clk3_en),
    .btn_in    (btn_reset),
    .level     (unused_levels[1]),
    .press     (clr_press)
  );

  // Next state, blink phase and time; adjust switch beats a same-cycle pause press
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    blink_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (adj)              state_d = ST_ADJ;
        else if (pause_press) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (adj)              state_d = ST_ADJ;
        else if (pause_press) state_d = ST_RUN;
      end
      ST_ADJ: begin
        if (!adj)             state_d = ST_PAUSE;
      end
      default: state_d = ST_RUN;
    endcase

    if (state_q == ST_ADJ) blink_d = blink_q ^ clk4_en;

    if (clr_press) begin
      time_d = '0;
    end else if (state_q == ST_RUN && clk1_en) begin
      time_d.ss = bcd2_inc(time_q.ss, SEC_MAX);
      if (time_q.ss == SEC_MAX) time_d.mm = bcd2_inc(time_q.mm, MIN_MAX);
    end else if (state_q == ST_ADJ && clk2_en) begin
      if (sel) time_d.ss = bcd2_inc(time_q.ss, SEC_MAX);
      else     time_d.mm = bcd2_inc(time_q.mm, MIN_MAX);
    end
  end

  // Flag outputs are registered from next-cycle values so they track state_q exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      adj_sync  <= '0;
      sel_sync  <= '0;
      state_q   <= ST_RUN;
      time_q    <= '0;
      blink_q   <= 1'b0;
      running   <= 1'b1;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      adj_sync  <= {adj_sync[0], sw_adj};
      sel_sync  <= {sel_sync[0], sw_sel};
      state_q   <= state_d;
      time_q    <= time_d;
      blink_q   <= blink_d;
      running   <= (state_d == ST_RUN);
      blank_min <= (state_d == ST_ADJ) & ~sel_sync[0] & blink_d;
      blank_sec <= (state_d == ST_ADJ) &  sel_sync[0] & blink_d;
    end
  end

  assign min_tens = time_q.mm.tens;
  assign min_ones = time_q.mm.ones;
  assign sec_tens = time_q.ss.tens;
  assign sec_ones = time_q.ss.ones;

endmodule
